// File: rtl/cmp_event_counter.sv
// cmp_event_counter
// Back end for the analog comparator. It re-times cmp_in into clk and debounces it.
// It produces one-cycle edge strobes and counts rising edges over a gate window.
// Optional feature macro: CMP_DUTY_EN. When it is defined, the block also accumulates
// the number of cycles in each window where cmp_filt is high.

module cmp_event_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 4,
    parameter int WIN_W       = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_in,
    input  logic [DEB_W-1:0] deb_len,
    input  logic [WIN_W-1:0] win_len,
    input  logic             start,
    output logic             cmp_filt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic [WIN_W-1:0] high_cycles
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   filt_q, filt_d;
    logic                   filt_prev_q, filt_prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    state_t                 state_q, state_d;
    logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   count_valid_q, count_valid_d;
    logic                   cmp_s;
    logic                   window_start;
    logic                   last_cycle;

    assign cmp_s        = sync_q[SYNC_STAGES-1];
    assign window_start = (state_q == IDLE) && start;
    assign last_cycle   = (state_q == COUNT) && (win_cnt_q <= WIN_W'(1));

    // The synchronizer shifts and the debounce counter counts how long the synchronized level has disagreed with cmp_filt
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], cmp_in};
        deb_cnt_d   = deb_cnt_q;
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        if (cmp_s == filt_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q >= deb_len) begin
            filt_d    = ~filt_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
        rise_d = filt_q & ~filt_prev_q;
        fall_d = ~filt_q & filt_prev_q;
    end

    // The measurement FSM opens a window, counts rise strobes with saturation, and publishes the result in DONE
    always_comb begin
        state_d       = state_q;
        win_cnt_d     = win_cnt_q;
        edge_cnt_d    = edge_cnt_q;
        ovf_acc_d     = ovf_acc_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        count_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = COUNT;
                    win_cnt_d  = win_len;
                    edge_cnt_d = '0;
                    ovf_acc_d  = 1'b0;
                end
            end
            COUNT: begin
                win_cnt_d = win_cnt_q - WIN_W'(1);
                if (rise_q) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        ovf_acc_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                if (last_cycle) begin
                    state_d       = DONE;
                    count_d       = edge_cnt_d;
                    overflow_d    = ovf_acc_d;
                    count_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register for the synchronizer, debounce, edge strobes and the measurement FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= '0;
            deb_cnt_q     <= '0;
            filt_q        <= 1'b0;
            filt_prev_q   <= 1'b0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            state_q       <= IDLE;
            win_cnt_q     <= '0;
            edge_cnt_q    <= '0;
            ovf_acc_q     <= 1'b0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            count_valid_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            deb_cnt_q     <= deb_cnt_d;
            filt_q        <= filt_d;
            filt_prev_q   <= filt_prev_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            state_q       <= state_d;
            win_cnt_q     <= win_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            ovf_acc_q     <= ovf_acc_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign cmp_filt    = filt_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign busy        = (state_q == COUNT);
    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign overflow    = overflow_q;

`ifdef CMP_DUTY_EN
    localparam logic [WIN_W-1:0] WIN_MAX = {WIN_W{1'b1}};

    logic [WIN_W-1:0] high_acc_q, high_acc_d;
    logic [WIN_W-1:0] high_cycles_q, high_cycles_d;

    // The accumulator counts window cycles where the filtered level is high, and the final value is latched with the edge count
    always_comb begin
        high_acc_d    = high_acc_q;
        high_cycles_d = high_cycles_q;
        if (window_start) begin
            high_acc_d = '0;
        end else if (state_q == COUNT) begin
            if (filt_q && (high_acc_q != WIN_MAX)) begin
                high_acc_d = high_acc_q + WIN_W'(1);
            end
            if (last_cycle) begin
                high_cycles_d = high_acc_d;
            end
        end
    end

    // Registers for the duty accumulator and its published result
    always_ff @(posedge clk) begin
        if (rst) begin
            high_acc_q    <= '0;
            high_cycles_q <= '0;
        end else begin
            high_acc_q    <= high_acc_d;
            high_cycles_q <= high_cycles_d;
        end
    end

    assign high_cycles = high_cycles_q;
`else
    assign high_cycles = '0;
`endif

endmodule

// File: tb/tb_cmp_event_counter.sv
// Testbench for cmp_event_counter. It uses a scoreboard of expected window results and
// directed checks for reset behaviour and debounce behaviour.
// The DUT is built with CNT_W=4 so that counter saturation can be reached.

module tb_cmp_event_counter;

    localparam int SYNC_STAGES = 2;
    localparam int DEB_W       = 4;
    localparam int WIN_W       = 16;
    localparam int CNT_W       = 4;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic [WIN_W-1:0] hc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             cmp_in;
    logic [DEB_W-1:0] deb_len;
    logic [WIN_W-1:0] win_len;
    logic             start;
    logic             cmp_filt;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             overflow;
    logic [WIN_W-1:0] high_cycles;

    exp_t sb[$];
    int   n_compared;
    int   n_mismatched;
    int   cv_seen;
    logic wave_en;
    int   wave_period;
    int   wave_high;
    int   wave_phase;

    cmp_event_counter #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_W(DEB_W),
        .WIN_W(WIN_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmp_in(cmp_in),
        .deb_len(deb_len),
        .win_len(win_len),
        .start(start),
        .cmp_filt(cmp_filt),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy(busy),
        .count(count),
        .count_valid(count_valid),
        .overflow(overflow),
        .high_cycles(high_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIN_W-1:0] duty(input int v);
`ifdef CMP_DUTY_EN
        return WIN_W'(v);
`else
        return WIN_W'(0 * v);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int win, input int deb);
        win_len = WIN_W'(win);
        deb_len = DEB_W'(deb);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("window_done_pending", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // The wave generator drives a periodic cmp_in pattern while wave_en is set
    initial begin
        wave_phase = 0;
        forever begin
            @(negedge clk);
            if (wave_en) begin
                wave_phase = (wave_phase + 1) % wave_period;
                cmp_in = (wave_phase < wave_high);
            end
        end
    end

    // The monitor pops one expected result from the scoreboard for each count_valid strobe
    initial begin
        exp_t e;
        cv_seen = 0;
        forever begin
            @(negedge clk);
            if (count_valid === 1'b1) begin
                cv_seen++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_count_valid", 32'(count_valid), 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("count", 32'(count), 32'(e.cnt));
                    checkOutput("overflow", 32'(overflow), 32'(e.ovf));
                    checkOutput("high_cycles", 32'(high_cycles), 32'(e.hc));
                end
            end
        end
    end

    initial begin
        int  nb;
        int  cv_snap;
        logic bad_filt;
        logic bad_pulse;
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        cmp_in       = 1'b0;
        start        = 1'b0;
        deb_len      = '0;
        win_len      = '0;
        wave_en      = 1'b0;
        wave_period  = 10;
        wave_high    = 5;

        // Reset is held for three cycles while cmp_in toggles
        repeat (3) begin
            @(negedge clk);
            cmp_in = ~cmp_in;
        end
        checkOutput("rst_cmp_filt", 32'(cmp_filt), 0);
        checkOutput("rst_rise", 32'(rise_pulse), 0);
        checkOutput("rst_fall", 32'(fall_pulse), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_count_valid", 32'(count_valid), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_high_cycles", 32'(high_cycles), 0);
        rst    = 1'b0;
        cmp_in = 1'b0;
        repeat (5) @(negedge clk);

        // With deb_len=3, cmp_filt should rise six cycles after the cmp_in edge
        deb_len = 4'd3;
        cmp_in  = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("deb_filt_early", 32'(cmp_filt), 0);
        @(negedge clk);
        checkOutput("deb_filt_set", 32'(cmp_filt), 1);
        checkOutput("deb_rise_not_yet", 32'(rise_pulse), 0);
        @(negedge clk);
        checkOutput("deb_rise_pulse", 32'(rise_pulse), 1);
        @(negedge clk);
        checkOutput("deb_rise_one_cycle", 32'(rise_pulse), 0);
        repeat (5) @(negedge clk);

        // A two-cycle low glitch is shorter than the debounce and must be absorbed
        bad_filt  = 1'b0;
        bad_pulse = 1'b0;
        cmp_in = 1'b0;
        repeat (2) @(negedge clk);
        cmp_in = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (cmp_filt !== 1'b1) bad_filt = 1'b1;
            if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0) bad_pulse = 1'b1;
        end
        checkOutput("glitch_filt_changed", 32'(bad_filt), 0);
        checkOutput("glitch_pulses", 32'(bad_pulse), 0);

        // A 100-cycle window over a period-10 square wave should contain ten rising edges
        deb_len     = '0;
        wave_period = 10;
        wave_high   = 5;
        wave_en     = 1'b1;
        repeat (20) @(negedge clk);
        sb.push_back('{cnt: 4'd10, ovf: 1'b0, hc: duty(50)});
        applyStimulus(100, 0);
        countBusy(nb);
        checkOutput("busy_cycles_100", nb, 100);
        waitDone(20);
        @(negedge clk);
        checkOutput("count_valid_one_cycle", 32'(count_valid), 0);

        // A start pulse in the middle of the window should be ignored
        repeat (5) @(negedge clk);
        sb.push_back('{cnt: 4'd10, ovf: 1'b0, hc: duty(50)});
        applyStimulus(100, 0);
        repeat (50) @(negedge clk);
        applyStimulus(100, 0);
        waitDone(300);

        // Reset in the middle of a window should abort it without a count_valid
        repeat (5) @(negedge clk);
        applyStimulus(100, 0);
        repeat (40) @(negedge clk);
        cv_snap = cv_seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_count", 32'(count), 0);
        checkOutput("midrst_count_valid", 32'(count_valid), 0);
        repeat (150) @(negedge clk);
        checkOutput("midrst_no_valid_later", cv_seen - cv_snap, 0);

        // A period-4 wave over 200 cycles saturates the 4-bit edge counter
        wave_period = 4;
        wave_high   = 2;
        repeat (20) @(negedge clk);
        sb.push_back('{cnt: 4'd15, ovf: 1'b1, hc: duty(100)});
        applyStimulus(200, 0);
        waitDone(400);
        repeat (10) @(negedge clk);
        checkOutput("hold_count", 32'(count), 15);
        checkOutput("hold_overflow", 32'(overflow), 1);

        // With win_len=0, the window lasts one COUNT cycle and a static input produces zero edges
        wave_en = 1'b0;
        cmp_in  = 1'b0;
        repeat (10) @(negedge clk);
        sb.push_back('{cnt: 4'd0, ovf: 1'b0, hc: duty(0)});
        applyStimulus(0, 0);
        countBusy(nb);
        checkOutput("busy_cycles_win0", nb, 1);
        waitDone(10);

        // A 30% duty wave gives 30 high cycles per 100-cycle window when the feature is built
        wave_period = 10;
        wave_high   = 3;
        wave_en     = 1'b1;
        repeat (20) @(negedge clk);
        sb.push_back('{cnt: 4'd10, ovf: 1'b0, hc: duty(30)});
        applyStimulus(100, 0);
        waitDone(300);

        wave_en = 1'b0;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
